// File: rtl/alu_share_arb.sv
// Two requesters share one combinational ALU. A combinational arbiter grants
// one request per cycle, and the result is captured into that port's response slot.

module alu_share_arb_alu (
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [3:0]  sel_i,
  input  logic        signed_i,
  output logic [31:0] result_o,
  output logic        z_o,
  output logic        n_o
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = op2_i[4:0];
  assign lt_s  = $signed(op1_i) < $signed(op2_i);
  assign lt_u  = op1_i < op2_i;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    result_o = '0;
    case (sel_i)
      4'b0000: result_o = op1_i + op2_i;
      4'b0001: result_o = op1_i - op2_i;
      4'b0010: result_o = op1_i & op2_i;
      4'b0011: result_o = op1_i | op2_i;
      4'b0100: result_o = op1_i ^ op2_i;
      4'b0101: result_o = op1_i << shamt;
      4'b0110: result_o = op1_i >> shamt;
      4'b0111: result_o = $signed(op1_i) >>> shamt;
      4'b1000: result_o = {31'b0, lt_s};
      4'b1001: result_o = {31'b0, lt_u};
      default: result_o = '0;
    endcase
    z_o = (result_o == '0);
    n_o = result_o[31];
    // SUB reports the true comparison, which can differ from the sign bit after overflow.
    if (sel_i == 4'b0001) n_o = signed_i ? lt_s : lt_u;
  end

endmodule

module alu_share_arb #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [63:0]      req_op1,
  input  logic [63:0]      req_op2,
  input  logic [7:0]       req_sel,
  input  logic [1:0]       req_signed,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [1:0]       rsp_z,
  output logic [1:0]       rsp_n,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0][31:0]  rsp_result_q, rsp_result_d;
  logic [1:0]        rsp_z_q, rsp_z_d;
  logic [1:0]        rsp_n_q, rsp_n_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic [1:0]  elig;
  logic [1:0]  grant;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_sel;
  logic        alu_signed, alu_z, alu_n;

  // A full slot can accept a new result when it is being drained in the same cycle.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (FIXED_PRIO || last_grant_q) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign alu_op1    = grant[1] ? req_op1[63:32] : req_op1[31:0];
  assign alu_op2    = grant[1] ? req_op2[63:32] : req_op2[31:0];
  assign alu_sel    = grant[1] ? req_sel[7:4]   : req_sel[3:0];
  assign alu_signed = grant[1] ? req_signed[1]  : req_signed[0];

  alu_share_arb_alu u_alu (
    .op1_i    (alu_op1),
    .op2_i    (alu_op2),
    .sel_i    (alu_sel),
    .signed_i (alu_signed),
    .result_o (alu_result),
    .z_o      (alu_z),
    .n_o      (alu_n)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_z_d      = rsp_z_q;
    rsp_n_d      = rsp_n_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = alu_result;
        rsp_z_d[i]      = alu_z;
        rsp_n_d[i]      = alu_n;
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i]  = 1'b0;
      end
    end
    if (|grant) begin
      last_grant_d = grant[1];
      op_count_d   = op_count_q + CNT_W'(1);
    end
  end

  // NOTE: the response slots are reset too, because their contents are visible
  // on the outputs and must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_z_q      <= '0;
      rsp_n_q      <= '0;
      last_grant_q <= 1'b1;
      op_count_q   <= '0;
    end else begin
      // NOTE: state is updated only with non-blocking assignments, so every
      // register samples its value from before the clock edge.
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_z_q      <= rsp_z_d;
      rsp_n_q      <= rsp_n_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_n      = rsp_n_q;
  assign busy       = (|rsp_valid_q) | (|req_valid);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: one round-robin instance and one fixed-priority
// instance, both driven by the same stimulus and checked against hand-computed values.

module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_signed, rsp_ready;
  logic [63:0] req_op1, req_op2;
  logic [7:0]  req_sel;

  logic [1:0]  req_ready, rsp_valid, rsp_z, rsp_n;
  logic [63:0] rsp_result;
  logic        busy;
  logic [15:0] op_count;

  logic [1:0]  req_ready_fp, rsp_valid_fp, rsp_z_fp, rsp_n_fp;
  logic [63:0] rsp_result_fp;
  logic        busy_fp;
  logic [15:0] op_count_fp;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        sg;
    logic [31:0] res;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_share_arb #(.FIXED_PRIO(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel), .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_z(rsp_z), .rsp_n(rsp_n), .busy(busy), .op_count(op_count)
  );

  alu_share_arb #(.FIXED_PRIO(1'b1), .CNT_W(16)) dut_fp (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_fp),
    .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel), .req_signed(req_signed),
    .rsp_valid(rsp_valid_fp), .rsp_ready(rsp_ready), .rsp_result(rsp_result_fp),
    .rsp_z(rsp_z_fp), .rsp_n(rsp_n_fp), .busy(busy_fp), .op_count(op_count_fp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic sg);
    req_op1[32*p +: 32] = a;
    req_op2[32*p +: 32] = b;
    req_sel[4*p +: 4]   = sel;
    req_signed[p]       = sg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic sg,
                         input logic [31:0] res, input logic z, input logic n);
    vec_t v;
    v.port = p; v.a = a; v.b = b; v.sel = sel; v.sg = sg;
    v.res = res; v.z = z; v.n = n;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_signed = '0; rsp_ready = '0;
    req_op1 = '0; req_op2 = '0; req_sel = '0;

    // Reset state
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_result", rsp_result, 64'h0);
    check("rst_flags", 64'({rsp_z, rsp_n}), 64'h0);
    check("rst_op_count", 64'(op_count), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Port 0 alone: SUB 5-7, signed
    set_req(0, 32'd5, 32'd7, 4'b0001, 1'b1);
    req_valid = 2'b01;
    #1;
    check("p0_req_ready", 64'(req_ready), 64'h1);
    check("p0_busy", 64'(busy), 64'h1);
    tick();
    req_valid = 2'b00;
    check("p0_rsp_valid", 64'(rsp_valid), 64'h1);
    check("p0_result", 64'(rsp_result[31:0]), 64'hFFFF_FFFE);
    check("p0_z", 64'(rsp_z[0]), 64'h0);
    check("p0_n", 64'(rsp_n[0]), 64'h1);
    check("p0_op_count", 64'(op_count), 64'h1);
    rsp_ready = 2'b01;
    tick();
    check("p0_drain", 64'(rsp_valid), 64'h0);

    // Reset pulse so that the next tie is the first tie after reset
    #2 rst = 1'b1;
    #2 rst = 1'b0;

    // Both ports valid every cycle, responses always consumed
    set_req(0, 32'd1, 32'h0000_0002, 4'b0000, 1'b0);
    set_req(1, 32'hF0, 32'hFF, 4'b0100, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_grant_%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      check($sformatf("rr_count_%0d", k), 64'(op_count), 64'(k + 1));
      if (k % 2 == 0) check($sformatf("rr_res0_%0d", k), 64'(rsp_result[31:0]), 64'h3);
      else            check($sformatf("rr_res1_%0d", k), 64'(rsp_result[63:32]), 64'h0F);
    end

    // Backpressure on port 0
    rsp_ready = 2'b10;
    #1;
    check("bp_first_grant", 64'(req_ready), 64'h1);
    tick();
    for (int j = 0; j < 3; j++) begin
      #1;
      check($sformatf("bp_grant_%0d", j), 64'(req_ready), 64'h2);
      check($sformatf("bp_hold_valid_%0d", j), 64'(rsp_valid[0]), 64'h1);
      check($sformatf("bp_hold_res_%0d", j), 64'(rsp_result[31:0]), 64'h3);
      tick();
    end
    rsp_ready = 2'b11;
    #1;
    check("bp_release_grant", 64'(req_ready), 64'h1);
    tick();
    check("bp_op_count", 64'(op_count), 64'd11);

    // Flag and operation vectors, one port at a time
    add_vec(0, 32'hFFFF_FFFF, 32'd1,         4'b1001, 1'b0, 32'h0,         1'b1, 1'b0);
    add_vec(1, 32'd1,         32'd2,         4'b0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    add_vec(0, 32'h8000_0000, 32'd35,        4'b0111, 1'b0, 32'hF000_0000, 1'b0, 1'b1);
    add_vec(1, 32'd5,         32'd6,         4'b1111, 1'b0, 32'h0,         1'b1, 1'b0);
    add_vec(0, 32'hFFFF_FFFF, 32'd1,         4'b1000, 1'b0, 32'h1,         1'b0, 1'b0);
    add_vec(1, 32'd1,         32'd31,        4'b0101, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    add_vec(0, 32'h8000_0000, 32'd4,         4'b0110, 1'b0, 32'h0800_0000, 1'b0, 1'b0);
    add_vec(1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0010, 1'b0, 32'h0000_F000, 1'b0, 1'b0);
    add_vec(0, 32'h0F,        32'hF0,        4'b0011, 1'b0, 32'hFF,        1'b0, 1'b0);
    add_vec(1, 32'h8000_0000, 32'd1,         4'b0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    add_vec(0, 32'h8000_0000, 32'd1,         4'b0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0);
    foreach (vecs[i]) begin
      set_req(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].sg);
      req_valid = (vecs[i].port == 0) ? 2'b01 : 2'b10;
      #1;
      check($sformatf("vec%0d_grant", i), 64'(req_ready), 64'(req_valid));
      tick();
      check($sformatf("vec%0d_res", i), 64'(rsp_result[32*vecs[i].port +: 32]), 64'(vecs[i].res));
      check($sformatf("vec%0d_z", i), 64'(rsp_z[vecs[i].port]), 64'(vecs[i].z));
      check($sformatf("vec%0d_n", i), 64'(rsp_n[vecs[i].port]), 64'(vecs[i].n));
    end

    // Fill both slots, then assert reset asynchronously between clock edges
    set_req(0, 32'd10, 32'd20, 4'b0000, 1'b0);
    set_req(1, 32'd7,  32'd7,  4'b0001, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
    tick();
    check("ar_both_full", 64'(rsp_valid), 64'h3);
    #2 rst = 1'b1;
    #1;
    check("ar_rsp_valid", 64'(rsp_valid), 64'h0);
    check("ar_op_count", 64'(op_count), 64'h0);
    check("ar_result", rsp_result, 64'h0);
    check("ar_fp_rsp_valid", 64'(rsp_valid_fp), 64'h0);
    rsp_ready = 2'b11;
    rst = 1'b0;
    #1;
    check("ar_first_tie", 64'(req_ready), 64'h1);
    check("fp_grant_0", 64'(req_ready_fp), 64'h1);
    tick();
    #1;
    check("ar_second_tie", 64'(req_ready), 64'h2);

    // Fixed priority: port 0 wins every tie
    for (int c = 1; c < 4; c++) begin
      check($sformatf("fp_grant_%0d", c), 64'(req_ready_fp), 64'h1);
      tick();
      #1;
    end
    rsp_ready = 2'b10;
    #1;
    check("fp_p0_full_grant", 64'(req_ready_fp), 64'h2);
    tick();
    req_valid = 2'b10;
    rsp_ready = 2'b11;
    #1;
    check("fp_p0_idle_grant", 64'(req_ready_fp), 64'h2);
    tick();
    check("fp_op_count", 64'(op_count_fp), 64'd6);
    check("fp_res1", 64'(rsp_result_fp[63:32]), 64'h0);
    check("fp_z1", 64'(rsp_z_fp[1]), 64'h1);

    // Drain everything: busy must fall
    req_valid = 2'b00;
    tick();
    check("idle_busy", 64'(busy), 64'h0);
    check("idle_busy_fp", 64'(busy_fp), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
